daio_rx_framer: RTL and testbench



---
 rtl/daio_pkg.sv | 28 ++
 rtl/daio_rx_subframe_shift.sv | 64 ++++++
 rtl/daio_rx_framer.sv | 206 ++++++++++++++++++++
 tb/tb_daio_rx_framer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/daio_pkg.sv
// daio_pkg
// Shared definitions for the DAIO receive path.
//   rx_state_t     : framer state (IDLE / HUNT / RUN)
//   ST_*           : bit positions inside the sticky status word
//   PRE_*          : {block, first, other} preamble strobe patterns
//   min1_clog2     : $clog2 clamped to a minimum width of one bit
package daio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HUNT = 2'd1,
        RUN  = 2'd2
    } rx_state_t;

    localparam int ST_CARRIER = 0;
    localparam int ST_BIPHASE = 1;
    localparam int ST_SYNC    = 2;
    localparam int ST_PARITY  = 3;

    localparam logic [2:0] PRE_BLOCK = 3'b100;
    localparam logic [2:0] PRE_FIRST = 3'b010;
    localparam logic [2:0] PRE_OTHER = 3'b001;

    function automatic int min1_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/daio_rx_subframe_shift.sv
// daio_rx_subframe_shift
// Subframe payload shift register plus running even-parity accumulator.
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   clear          : drop any partial payload and zero the parity accumulator
//   shift_en       : shift bit_in in at the MSB and fold it into the parity
//   capture        : bit_in is the P bit; latch the finished word to the outputs
//   parity_en      : qualifies the parity error result
//   bit_in         : decoded bit
//   word_perr      : parity error of the word completing this cycle (combinational)
//   data/vuc/perr  : registered audio word, {V,U,C} and parity error of the last word
module daio_rx_subframe_shift
    import daio_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              capture,
    input  logic              parity_en,
    input  logic              bit_in,
    output logic              word_perr,
    output logic [DATA_W-1:0] data,
    output logic [2:0]        vuc,
    output logic              perr
);

    // The full payload is DATA_W+4 bits. Only DATA_W+3 of them are stored:
    // the final (P) bit is still on bit_in when the word is captured, so the
    // complete word exists as 'word' in that cycle and is latched directly.
    logic [DATA_W+2:0] sr;
    logic              acc;
    logic [DATA_W+3:0] word;

    assign word      = {bit_in, sr};
    assign word_perr = parity_en & (acc ^ bit_in);

    always_ff @(posedge clock) begin
        if (reset) begin
            sr   <= '0;
            acc  <= 1'b0;
            data <= '0;
            vuc  <= '0;
            perr <= 1'b0;
        end else begin
            if (clear) begin
                sr  <= '0;
                acc <= 1'b0;
            end else if (shift_en) begin
                sr  <= word[DATA_W+3:1];
                // Accumulator restarts for the next subframe once P is folded in.
                acc <= capture ? 1'b0 : (acc ^ bit_in);
            end
            if (capture && !clear) begin
                data <= word[DATA_W-1:0];
                // Time order is V, U, C, so V sits lowest above the audio word.
                vuc  <= {word[DATA_W], word[DATA_W+1], word[DATA_W+2]};
                perr <= word_perr;
            end
        end
    end

endmodule

// File: rtl/daio_rx_framer.sv
// daio_rx_framer
// Receive framer: assembles bit_valid-qualified decoded bits into subframes
// for CHANNELS channels, extracts audio word and V/U/C, checks parity and the
// preamble sequence, and issues sample / buffer-load / block strobes.
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   enable                    : receiver enable (0 forces IDLE)
//   parity_en                 : enables parity error flagging
//   status_clear              : clears sticky status (a same-cycle set wins)
//   bit_valid, bit_in         : decoded bit and its qualifier
//   preamble_block/first/other: preamble strobes on the last preamble slot
//   carrier_loss, biphase_violation : decoder error indications
//   sample_data/vuc/chan/perr : last sample, held until the next one
//   sample_valid              : one-cycle pulse per presented sample
//   load_buff, block_done     : one-cycle pulses on the last channel's sample
//   frame_count               : frame index within the block
//   locked                    : high while in RUN
//   status                    : sticky {parity, sync, biphase, carrier}
module daio_rx_framer
    import daio_pkg::*;
#(
    parameter  int CHANNELS         = 2,
    parameter  int SUBFRAME_BITS    = 32,
    parameter  int PREAMBLE_BITS    = 4,
    parameter  int DATA_W           = 24,
    parameter  int FRAMES_PER_BLOCK = 192,
    parameter  int BUFF_FRAMES      = 4,
    parameter  int AUTO_RESYNC      = 1,
    localparam int CH_W             = min1_clog2(CHANNELS),
    localparam int FC_W             = $clog2(FRAMES_PER_BLOCK)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              parity_en,
    input  logic              status_clear,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              preamble_block,
    input  logic              preamble_first,
    input  logic              preamble_other,
    input  logic              carrier_loss,
    input  logic              biphase_violation,
    output logic [DATA_W-1:0] sample_data,
    output logic [2:0]        sample_vuc,
    output logic [CH_W-1:0]   sample_chan,
    output logic              sample_perr,
    output logic              sample_valid,
    output logic              load_buff,
    output logic              block_done,
    output logic [FC_W-1:0]   frame_count,
    output logic              locked,
    output logic [3:0]        status
);

    localparam int BC_W = min1_clog2(SUBFRAME_BITS);
    localparam int BF_W = min1_clog2(BUFF_FRAMES);

    localparam logic [BC_W-1:0] FIRST_DATA = BC_W'(PREAMBLE_BITS);
    localparam logic [BC_W-1:0] LAST_PRE   = BC_W'(PREAMBLE_BITS - 1);
    localparam logic [BC_W-1:0] LAST_BIT   = BC_W'(SUBFRAME_BITS - 1);
    localparam logic [CH_W-1:0] LAST_CH    = CH_W'(CHANNELS - 1);
    localparam logic [FC_W-1:0] LAST_FRAME = FC_W'(FRAMES_PER_BLOCK - 1);
    localparam logic [BF_W-1:0] LAST_BUF   = BF_W'(BUFF_FRAMES - 1);

    rx_state_t       state;
    logic [BC_W-1:0] bit_cnt;
    logic [CH_W-1:0] chan;
    // Completed frames modulo BUFF_FRAMES; BUFF_FRAMES divides the block,
    // so it is naturally back at zero whenever frame_count wraps.
    logic [BF_W-1:0] buf_cnt;

    logic       run_go;
    logic       adv;
    logic       sync_slot;
    logic       eos;
    logic       expected_pre;
    logic       sync_err;
    logic       resync;
    logic       shift_en;
    logic       sr_clear;
    logic       word_perr;
    logic [3:0] st_set;

    // RUN continues this cycle only if neither disable nor carrier loss
    // pre-empts it; every RUN-side action is gated by this.
    assign run_go    = (state == RUN) && enable && !carrier_loss;
    assign adv       = run_go && bit_valid;
    assign sync_slot = adv && (bit_cnt == LAST_PRE);
    assign eos       = adv && (bit_cnt == LAST_BIT);
    assign shift_en  = adv && (bit_cnt >= FIRST_DATA);

    always_comb begin
        expected_pre = preamble_other;
        if (chan == '0)
            expected_pre = (frame_count == '0) ? preamble_block : preamble_first;
    end

    assign sync_err = sync_slot && !expected_pre;
    assign resync   = sync_err && (AUTO_RESYNC != 0);
    assign sr_clear = !run_go || resync;

    always_comb begin
        st_set              = '0;
        st_set[ST_CARRIER]  = (state != IDLE) && carrier_loss;
        st_set[ST_BIPHASE]  = (state != IDLE) && biphase_violation;
        st_set[ST_SYNC]     = sync_err;
        st_set[ST_PARITY]   = eos && word_perr;
    end

    assign locked = (state == RUN);

    daio_rx_subframe_shift #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clock     (clock),
        .reset     (reset),
        .clear     (sr_clear),
        .shift_en  (shift_en),
        .capture   (eos),
        .parity_en (parity_en),
        .bit_in    (bit_in),
        .word_perr (word_perr),
        .data      (sample_data),
        .vuc       (sample_vuc),
        .perr      (sample_perr)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            chan         <= '0;
            buf_cnt      <= '0;
            frame_count  <= '0;
            sample_chan  <= '0;
            sample_valid <= 1'b0;
            load_buff    <= 1'b0;
            block_done   <= 1'b0;
            status       <= '0;
        end else begin
            sample_valid <= 1'b0;
            load_buff    <= 1'b0;
            block_done   <= 1'b0;
            status       <= (status & {4{~status_clear}}) | st_set;

            if (!enable) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                chan        <= '0;
                buf_cnt     <= '0;
                frame_count <= '0;
            end else begin
                case (state)
                    IDLE: state <= HUNT;

                    HUNT: begin
                        if (bit_valid && preamble_block) begin
                            state       <= RUN;
                            bit_cnt     <= FIRST_DATA;
                            chan        <= '0;
                            buf_cnt     <= '0;
                            frame_count <= '0;
                        end
                    end

                    RUN: begin
                        if (carrier_loss) begin
                            state <= HUNT;
                        end else if (bit_valid) begin
                            if (resync) begin
                                // A block preamble in the wrong place is still a
                                // valid lock point: restart the block right here.
                                if (preamble_block) begin
                                    bit_cnt     <= FIRST_DATA;
                                    chan        <= '0;
                                    buf_cnt     <= '0;
                                    frame_count <= '0;
                                end else begin
                                    state <= HUNT;
                                end
                            end else if (bit_cnt == LAST_BIT) begin
                                bit_cnt      <= '0;
                                sample_valid <= 1'b1;
                                sample_chan  <= chan;
                                if (chan == LAST_CH) begin
                                    chan        <= '0;
                                    frame_count <= (frame_count == LAST_FRAME) ? '0 : frame_count + 1'b1;
                                    buf_cnt     <= (buf_cnt == LAST_BUF) ? '0 : buf_cnt + 1'b1;
                                    load_buff   <= (buf_cnt == LAST_BUF);
                                    block_done  <= (frame_count == LAST_FRAME);
                                end else begin
                                    chan <= chan + 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_daio_rx_framer.sv
// tb_daio_rx_framer
// Directed bench for daio_rx_framer. Two instances: defaults (dut0) and a
// 6-channel, 8-frame-block variant (dut6). Stimulus builds subframes from
// (frame, channel) and queues the sample each one must produce; a negedge
// process checks every sample and strobe against that queue.
module tb_daio_rx_framer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0, enable6 = 1'b0;
    logic parity_en = 1'b1, status_clear = 1'b0;
    logic bit_valid = 1'b0, bit_in = 1'b0;
    logic preamble_block = 1'b0, preamble_first = 1'b0, preamble_other = 1'b0;
    logic carrier_loss = 1'b0, biphase_violation = 1'b0;

    always #5 clock = ~clock;

    logic [23:0] sd0, sd6;
    logic [2:0]  sv0, sv6;
    logic [0:0]  sc0;
    logic [2:0]  sc6;
    logic        sp0, sp6, svl0, svl6, lb0, lb6, bd0, bd6, lk0, lk6;
    logic [7:0]  fc0;
    logic [2:0]  fc6;
    logic [3:0]  st0, st6;

    daio_rx_framer u_dut0 (
        .clock(clock), .reset(reset), .enable(enable), .parity_en(parity_en),
        .status_clear(status_clear), .bit_valid(bit_valid), .bit_in(bit_in),
        .preamble_block(preamble_block), .preamble_first(preamble_first),
        .preamble_other(preamble_other), .carrier_loss(carrier_loss),
        .biphase_violation(biphase_violation),
        .sample_data(sd0), .sample_vuc(sv0), .sample_chan(sc0), .sample_perr(sp0),
        .sample_valid(svl0), .load_buff(lb0), .block_done(bd0),
        .frame_count(fc0), .locked(lk0), .status(st0)
    );

    daio_rx_framer #(.CHANNELS(6), .FRAMES_PER_BLOCK(8), .BUFF_FRAMES(2)) u_dut6 (
        .clock(clock), .reset(reset), .enable(enable6), .parity_en(parity_en),
        .status_clear(status_clear), .bit_valid(bit_valid), .bit_in(bit_in),
        .preamble_block(preamble_block), .preamble_first(preamble_first),
        .preamble_other(preamble_other), .carrier_loss(carrier_loss),
        .biphase_violation(biphase_violation),
        .sample_data(sd6), .sample_vuc(sv6), .sample_chan(sc6), .sample_perr(sp6),
        .sample_valid(svl6), .load_buff(lb6), .block_done(bd6),
        .frame_count(fc6), .locked(lk6), .status(st6)
    );

    typedef struct {
        logic [23:0] data;
        logic [2:0]  vuc;
        int          chan;
        logic        perr;
        logic        load;
        logic        bdone;
        int          fc;
    } smp_t;

    smp_t q0[$], q6[$], log0[$], log6[$];
    int   errors = 0, checks = 0;
    int   n_sv0 = 0, n_lb0 = 0, n_bd0 = 0, n_sv6 = 0, n_lb6 = 0, n_bd6 = 0;

    // stream model context
    int tgt = 0, nch = 2, fpb = 192, bfr = 4, mf = 0;
    bit gaps = 1'b0, a5 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input smp_t o, input smp_t e);
        checks++;
        if (o.data !== e.data || o.vuc !== e.vuc || o.chan != e.chan || o.perr !== e.perr ||
            o.load !== e.load || o.bdone !== e.bdone || o.fc != e.fc) begin
            errors++;
            $display("FAIL %s sample: got d=%h vuc=%b ch=%0d p=%b lb=%b bd=%b fc=%0d, expected d=%h vuc=%b ch=%0d p=%b lb=%b bd=%b fc=%0d",
                     tag, o.data, o.vuc, o.chan, o.perr, o.load, o.bdone, o.fc,
                     e.data, e.vuc, e.chan, e.perr, e.load, e.bdone, e.fc);
        end
    endtask

    always @(negedge clock) begin
        smp_t o, e;
        checks++;
        if (!svl0 && (lb0 || bd0)) begin
            errors++;
            $display("FAIL dut0 stray strobe: lb=%b bd=%b without sample_valid", lb0, bd0);
        end
        if (svl0) begin
            o = '{sd0, sv0, int'(sc0), sp0, lb0, bd0, int'(fc0)};
            log0.push_back(o);
            n_sv0++; n_lb0 += int'(lb0); n_bd0 += int'(bd0);
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0 unexpected sample: got d=%h ch=%0d, expected none", sd0, sc0);
            end else begin
                e = q0.pop_front();
                cmp("dut0", o, e);
            end
        end
        checks++;
        if (!svl6 && (lb6 || bd6)) begin
            errors++;
            $display("FAIL dut6 stray strobe: lb=%b bd=%b without sample_valid", lb6, bd6);
        end
        if (svl6) begin
            o = '{sd6, sv6, int'(sc6), sp6, lb6, bd6, int'(fc6)};
            log6.push_back(o);
            n_sv6++; n_lb6 += int'(lb6); n_bd6 += int'(bd6);
            if (q6.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut6 unexpected sample: got d=%h ch=%0d, expected none", sd6, sc6);
            end else begin
                e = q6.pop_front();
                cmp("dut6", o, e);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [23:0] data_of(input int f, input int c);
        logic [31:0] h;
        h = 32'(f * 37 + c * 11 + 5) * 32'h9E3779B1;
        return h[27:4];
    endfunction

    // One decoded bit; in gap mode it is preceded by 0-2 invalid cycles
    // carrying garbage that the framer must ignore.
    task automatic bit_cycle(input logic b, input logic [2:0] pre);
        if (gaps) begin
            int n;
            n = int'($urandom_range(0, 2));
            repeat (n) begin
                bit_valid = 1'b0;
                bit_in    = 1'($urandom);
                {preamble_block, preamble_first, preamble_other} = 3'($urandom);
                tick();
            end
        end
        bit_valid = 1'b1;
        bit_in    = b;
        {preamble_block, preamble_first, preamble_other} = pre;
        tick();
        bit_valid = 1'b0;
        {preamble_block, preamble_first, preamble_other} = 3'b000;
    endtask

    // Subframe: 4 preamble slots (strobe on slot 3), audio LSB first,
    // then V, U, C and an even-parity P (optionally inverted).
    task automatic send_sub(input logic [2:0] pre, input logic [23:0] d, input logic [2:0] vuc,
                            input bit flip, input int nbits);
        logic [31:0] sf;
        sf[3:0]   = 4'b0011;
        sf[27:4]  = d;
        sf[28]    = vuc[2];
        sf[29]    = vuc[1];
        sf[30]    = vuc[0];
        sf[31]    = (^{d, vuc}) ^ flip;
        for (int i = 0; i < nbits; i++)
            bit_cycle(sf[i], (i == 3) ? pre : 3'b000);
    endtask

    task automatic run_frames(input int nfr, input int flip_f, input int flip_c,
                              input int drop_f, input int drop_c);
        for (int k = 0; k < nfr; k++) begin
            for (int c = 0; c < nch; c++) begin
                logic [2:0]  pre, vuc;
                logic [23:0] d;
                bit          fl, dr;
                smp_t        e;
                pre = (c != 0) ? 3'b001 : (((mf % fpb) == 0) ? 3'b100 : 3'b010);
                fl  = (mf == flip_f) && (c == flip_c);
                dr  = (mf == drop_f) && (c == drop_c);
                if (a5 && (mf % fpb) == 0 && c == 0) begin
                    d = 24'hA5C3F0; vuc = 3'b101;
                end else begin
                    d = data_of(mf, c); vuc = 3'(mf + c);
                end
                if (!dr) begin
                    e.data  = d;
                    e.vuc   = vuc;
                    e.chan  = c;
                    e.perr  = fl && parity_en;
                    e.load  = (c == nch - 1) && (((mf % fpb) + 1) % bfr == 0);
                    e.bdone = (c == nch - 1) && ((mf % fpb) == fpb - 1);
                    e.fc    = (c == nch - 1) ? ((mf + 1) % fpb) : (mf % fpb);
                    if (tgt == 0) q0.push_back(e); else q6.push_back(e);
                end
                send_sub(dr ? 3'b000 : pre, d, vuc, fl, 32);
                if (dr) return;
            end
            mf++;
        end
    endtask

    initial begin
        int b, sv_before, mism;

        // reset state
        repeat (3) tick();
        check("rst_valid", {svl0, lb0, bd0}, 3'b000);
        check("rst_data", {sd0, sv0, sc0, sp0}, '0);
        check("rst_fc", fc0, 0);
        check("rst_status", st0, 0);
        check("rst_locked", {lk0, lk6}, 2'b00);
        reset = 1'b0;
        tick();

        // biphase sticky outside IDLE, then clear
        enable = 1'b1; tick();
        biphase_violation = 1'b1; tick(); biphase_violation = 1'b0;
        check("biphase_sticky", st0, 4'b0010);
        status_clear = 1'b1; tick(); status_clear = 1'b0;
        check("status_clear", st0, 4'b0000);

        // clean full block
        mf = 0;
        run_frames(192, -1, -1, -1, -1);
        tick();
        check("block_samples", n_sv0, 384);
        check("block_loads", n_lb0, 48);
        check("block_done_cnt", n_bd0, 1);
        check("block_status", st0, 0);
        check("block_locked", lk0, 1);

        // data extraction and parity error on frame 10 ch1 of the next block
        a5 = 1'b1;
        b  = log0.size();
        run_frames(12, 192 + 10, 1, -1, -1);
        tick();
        a5 = 1'b0;
        check("a5_data", log0[b].data, 24'hA5C3F0);
        check("a5_vuc", log0[b].vuc, 3'b101);
        check("a5_perr", log0[b].perr, 0);
        check("perr_before", log0[b + 20].perr, 0);
        check("perr_flipped", log0[b + 21].perr, 1);
        check("perr_after", log0[b + 22].perr, 0);
        check("parity_sticky", st0, 4'b1000);
        check("fc_after_12", fc0, 12);

        // parity check disabled
        status_clear = 1'b1; tick(); status_clear = 1'b0;
        check("parity_cleared", st0, 0);
        parity_en = 1'b0;
        b = log0.size();
        run_frames(2, mf, 0, -1, -1);
        tick();
        check("noparity_perr", log0[b].perr, 0);
        check("noparity_status", st0, 0);
        parity_en = 1'b1;

        // disable mid-subframe: bit 17 arrives with enable low
        sv_before = n_sv0;
        send_sub(3'b010, 24'h123456, 3'b000, 1'b0, 17);
        enable = 1'b0;
        bit_cycle(1'b1, 3'b000);
        repeat (40) bit_cycle(1'b0, 3'b000);
        check("disable_nosample", n_sv0, sv_before);
        check("disable_locked", lk0, 0);

        // sync error: preamble_other missing on frame 5, then relock
        enable = 1'b1; tick(); tick();
        mf = 0;
        run_frames(8, -1, -1, 5, 1);
        tick();
        check("sync_status", st0[2], 1);
        check("sync_locked", lk0, 0);
        check("sync_samples", n_sv0 - sv_before, 11);
        mf = 0;
        b  = log0.size();
        run_frames(1, -1, -1, -1, -1);
        tick();
        check("relock_fc0", log0[b].fc, 0);
        check("relock_locked", lk0, 1);
        check("relock_fc", fc0, 1);

        // carrier loss in RUN
        carrier_loss = 1'b1; tick(); carrier_loss = 1'b0;
        check("carrier_locked", lk0, 0);
        check("carrier_status", st0, 4'b0101);

        // reset mid-block
        mf = 0;
        run_frames(3, -1, -1, -1, -1);
        send_sub(3'b010, 24'h0F0F0F, 3'b010, 1'b0, 10);
        check("prereset_fc", fc0, 3);
        reset = 1'b1; tick();
        check("reset_fc", fc0, 0);
        check("reset_status", st0, 0);
        check("reset_outputs", {svl0, lb0, bd0, lk0, sd0, sv0, sc0, sp0}, '0);
        reset = 1'b0; enable = 1'b0; tick();

        // 6 channels, gapless then with bit_valid gaps
        tgt = 1; nch = 6; fpb = 8; bfr = 2;
        enable6 = 1'b1; tick(); tick();
        mf = 0;
        run_frames(8, -1, -1, -1, -1);
        tick();
        check("ch6_samples", n_sv6, 48);
        check("ch6_loads", n_lb6, 4);
        check("ch6_blocks", n_bd6, 1);
        enable6 = 1'b0; tick();
        enable6 = 1'b1; tick(); tick();
        gaps = 1'b1;
        mf   = 0;
        run_frames(8, -1, -1, -1, -1);
        gaps = 1'b0;
        tick();
        check("ch6_gap_samples", n_sv6, 96);
        check("ch6_gap_loads", n_lb6, 8);
        check("ch6_gap_blocks", n_bd6, 2);
        mism = 0;
        for (int i = 0; i < 48 && i + 48 < log6.size(); i++) begin
            checks++;
            if (log6[i] != log6[i + 48] || log6[i].chan != i % 6) begin
                errors++; mism++;
                $display("FAIL ch6_gap_seq[%0d]: got d=%h ch=%0d, expected d=%h ch=%0d",
                         i, log6[i + 48].data, log6[i + 48].chan, log6[i].data, i % 6);
            end
        end
        check("queues_drained", q0.size() + q6.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
